// File: rtl/jtframe_keymap.sv
// PS/2 keyboard front-end: bit receiver, scan-code parser and arcade key map.
// Optional macro JTFRAME_KEYMAP_PAUSE_TOGGLE_EN makes key_pause toggle on each press.
module jtframe_keymap #(
   parameter int          PLAYERS = 2,
   parameter int          BUTTONS = 4,
   parameter logic [15:0] TIMEOUT = 16'd48000
)(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            ps2_clk,
   input  logic                            ps2_data,
   output logic [PLAYERS*(4+BUTTONS)-1:0]  key_joy,
   output logic [PLAYERS-1:0]              key_coin,
   output logic [PLAYERS-1:0]              key_start,
   output logic                            key_service,
   output logic                            key_reset,
   output logic                            key_pause,
   output logic [7:0]                      rx_byte,
   output logic                            rx_valid,
   output logic                            rx_err,
   output logic [2:0]                      dbg_state
);

   localparam int W  = 4 + BUTTONS;
   localparam int JW = PLAYERS * W;

   typedef enum logic [2:0] {IDLE, EXT, REL, EXTREL, SKIP} st_t;

   logic [2:0]  clk_s, dat_s;
   logic [3:0]  bit_cnt;
   logic [9:0]  sreg;
   logic [15:0] to_cnt;
   logic        fall;

   st_t         st, st_nx;
   logic [2:0]  skip_cnt, skip_nx;
   logic        dec, clr, ext, rel;
   int          jp, jn, cp, sp;
   logic [2:0]  sys_hit;
   logic [JW-1:0]      joy_mask;
   logic [PLAYERS-1:0] coin_mask, start_mask;

   assign fall      = clk_s[2] & ~clk_s[1];
   assign dbg_state = st;

   // rx_valid/rx_err are single-cycle strobes without back-pressure: a consumer
   // must take rx_byte in the very cycle rx_valid is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s    <= 3'b000;
         dat_s    <= 3'b000;
         bit_cnt  <= 4'd0;
         sreg     <= 10'd0;
         to_cnt   <= 16'd0;
         rx_byte  <= 8'h00;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
      end else begin
         clk_s    <= {clk_s[1:0], ps2_clk};
         dat_s    <= {dat_s[1:0], ps2_data};
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         if (fall) begin
            to_cnt <= 16'd0;
            if (bit_cnt == 4'd10) begin
               bit_cnt <= 4'd0;
               // sreg holds {parity, data[7:0], start}; dat_s[1] is the stop bit
               if (!sreg[0] && (^sreg[9:1]) && dat_s[1]) begin
                  rx_valid <= 1'b1;
                  rx_byte  <= sreg[8:1];
               end else begin
                  rx_err <= 1'b1;
               end
            end else begin
               sreg    <= {dat_s[1], sreg[9:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (bit_cnt != 4'd0) begin
            if (to_cnt >= TIMEOUT - 16'd1) begin
               bit_cnt <= 4'd0;
               to_cnt  <= 16'd0;
               rx_err  <= 1'b1;
            end else begin
               to_cnt <= to_cnt + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= IDLE;
         skip_cnt <= 3'd0;
      end else begin
         st       <= st_nx;
         skip_cnt <= skip_nx;
      end
   end

   always_comb begin
      st_nx   = st;
      skip_nx = skip_cnt;
      dec     = 1'b0;
      clr     = 1'b0;
      ext     = (st == EXT) || (st == EXTREL);
      rel     = (st == REL) || (st == EXTREL);
      if (rx_err) begin
         st_nx   = IDLE;
         skip_nx = 3'd0;
      end else if (rx_valid) begin
         if (st == SKIP) begin
            skip_nx = skip_cnt - 3'd1;
            if (skip_cnt == 3'd1) st_nx = IDLE;
         end else if (rx_byte == 8'hAA || rx_byte == 8'h00 || rx_byte == 8'hFF) begin
            clr   = 1'b1;
            st_nx = IDLE;
         end else if (rx_byte == 8'hE1) begin
            st_nx   = SKIP;
            skip_nx = 3'd7;
         end else if (rx_byte == 8'hE0 && st == IDLE) begin
            st_nx = EXT;
         end else if (rx_byte == 8'hF0 && st == IDLE) begin
            st_nx = REL;
         end else if (rx_byte == 8'hF0 && st == EXT) begin
            st_nx = EXTREL;
         end else begin
            dec   = 1'b1;
            st_nx = IDLE;
         end
      end
   end

   // Key map: jp/jn select player and joystick bit, cp/sp coin/start player
   always_comb begin
      jp = -1; jn = 0; cp = -1; sp = -1;
      sys_hit = 3'b000;
      case ({ext, rx_byte})
         9'h174: begin jp = 0; jn = 0; end
         9'h16B: begin jp = 0; jn = 1; end
         9'h172: begin jp = 0; jn = 2; end
         9'h175: begin jp = 0; jn = 3; end
         9'h014: begin jp = 0; jn = 4; end
         9'h011: begin jp = 0; jn = 5; end
         9'h029: begin jp = 0; jn = 6; end
         9'h012: begin jp = 0; jn = 7; end
         9'h034: begin jp = 1; jn = 0; end
         9'h023: begin jp = 1; jn = 1; end
         9'h02B: begin jp = 1; jn = 2; end
         9'h02D: begin jp = 1; jn = 3; end
         9'h01C: begin jp = 1; jn = 4; end
         9'h01B: begin jp = 1; jn = 5; end
         9'h015: begin jp = 1; jn = 6; end
         9'h01D: begin jp = 1; jn = 7; end
         9'h04B: begin jp = 2; jn = 0; end
         9'h03B: begin jp = 2; jn = 1; end
         9'h042: begin jp = 2; jn = 2; end
         9'h043: begin jp = 2; jn = 3; end
         9'h05A: begin jp = 2; jn = 4; end
         9'h059: begin jp = 2; jn = 5; end
         9'h044: begin jp = 2; jn = 6; end
         9'h04D: begin jp = 2; jn = 7; end
         9'h02E: cp = 0;
         9'h036: cp = 1;
         9'h03D: cp = 2;
         9'h016, 9'h005: sp = 0;
         9'h01E, 9'h006: sp = 1;
         9'h026: sp = 2;
         9'h046: sys_hit = 3'b001;
         9'h004: sys_hit = 3'b010;
         9'h00C: sys_hit = 3'b100;
         default: ;
      endcase
      joy_mask   = '0;
      coin_mask  = '0;
      start_mask = '0;
      if (jp >= 0 && jp < PLAYERS && jn < W) joy_mask = JW'(1) << (jp * W + jn);
      if (cp >= 0 && cp < PLAYERS) coin_mask  = PLAYERS'(1) << cp;
      if (sp >= 0 && sp < PLAYERS) start_mask = PLAYERS'(1) << sp;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_joy     <= '0;
         key_coin    <= '0;
         key_start   <= '0;
         key_service <= 1'b0;
         key_reset   <= 1'b0;
         key_pause   <= 1'b0;
      end else if (clr) begin
         key_joy     <= '0;
         key_coin    <= '0;
         key_start   <= '0;
         key_service <= 1'b0;
         key_reset   <= 1'b0;
         key_pause   <= 1'b0;
      end else if (dec) begin
         key_joy   <= rel ? (key_joy & ~joy_mask)     : (key_joy | joy_mask);
         key_coin  <= rel ? (key_coin & ~coin_mask)   : (key_coin | coin_mask);
         key_start <= rel ? (key_start & ~start_mask) : (key_start | start_mask);
         if (sys_hit[0]) key_service <= !rel;
         if (sys_hit[1]) key_reset   <= !rel;
`ifdef JTFRAME_KEYMAP_PAUSE_TOGGLE_EN
         if (sys_hit[2] && !rel) key_pause <= !key_pause;
`else
         if (sys_hit[2]) key_pause <= !rel;
`endif
      end
   end

endmodule

// File: tb/tb_jtframe_keymap.sv
// Randomised bench for jtframe_keymap against a byte-stream reference model.
module tb_jtframe_keymap;

   localparam int          P    = 2;
   localparam int          B    = 4;
   localparam int          W    = 4 + B;
   localparam logic [15:0] TO   = 16'd300;
   localparam int          HALF = 6;

   logic clk, rst_n, ps2_clk, ps2_data;
   logic [P*W-1:0] key_joy;
   logic [P-1:0]   key_coin, key_start;
   logic           key_service, key_reset, key_pause;
   logic [7:0]     rx_byte;
   logic           rx_valid, rx_err;
   logic [2:0]     dbg_state;

   jtframe_keymap #(.PLAYERS(P), .BUTTONS(B), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_joy(key_joy), .key_coin(key_coin), .key_start(key_start),
      .key_service(key_service), .key_reset(key_reset), .key_pause(key_pause),
      .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err), .dbg_state(dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   int total = 0;
   int bad = 0;
   int err_seen = 0;
   int err_exp = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;

   // reference model state
   logic [P*W-1:0] m_joy;
   logic [P-1:0]   m_coin, m_start;
   logic           m_svc, m_rst, m_pause, m_ext, m_rel;
   int             m_skip;

   // joystick table indexed by player*8 + bit; bit 8 set means E0-prefixed
   logic [8:0] joy_tab[24] = '{
      9'h174, 9'h16B, 9'h172, 9'h175, 9'h014, 9'h011, 9'h029, 9'h012,
      9'h034, 9'h023, 9'h02B, 9'h02D, 9'h01C, 9'h01B, 9'h015, 9'h01D,
      9'h04B, 9'h03B, 9'h042, 9'h043, 9'h05A, 9'h059, 9'h044, 9'h04D};
   logic [7:0] coin_tab[3]  = '{8'h2E, 8'h36, 8'h3D};
   logic [7:0] start_tab[5] = '{8'h16, 8'h05, 8'h1E, 8'h06, 8'h26};
   int         start_pl[5]  = '{0, 0, 1, 1, 2};
   logic [7:0] pool[37] = '{
      8'h14, 8'h11, 8'h29, 8'h12, 8'h1C, 8'h1B, 8'h15, 8'h1D, 8'h2D, 8'h2B,
      8'h23, 8'h34, 8'h43, 8'h42, 8'h3B, 8'h4B, 8'h5A, 8'h59, 8'h44, 8'h4D,
      8'h2E, 8'h36, 8'h3D, 8'h16, 8'h05, 8'h1E, 8'h06, 8'h26, 8'h46, 8'h04,
      8'h0C, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h12, 8'h55};

   function automatic void model_clear();
      m_joy = '0; m_coin = '0; m_start = '0;
      m_svc = 0; m_rst = 0; m_pause = 0;
   endfunction

   function automatic void model_err();
      m_ext = 0; m_rel = 0; m_skip = 0;
   endfunction

   function automatic void model_apply(input logic [7:0] c);
      logic [8:0] key;
      key = {m_ext, c};
      for (int i = 0; i < 24; i++)
         if (joy_tab[i] == key && i / 8 < P && i % 8 < W) m_joy[i / 8 * W + i % 8] = !m_rel;
      if (!m_ext) begin
         for (int i = 0; i < 3; i++)
            if (coin_tab[i] == c && i < P) m_coin[i] = !m_rel;
         for (int i = 0; i < 5; i++)
            if (start_tab[i] == c && start_pl[i] < P) m_start[start_pl[i]] = !m_rel;
         if (c == 8'h46) m_svc = !m_rel;
         if (c == 8'h04) m_rst = !m_rel;
`ifdef JTFRAME_KEYMAP_PAUSE_TOGGLE_EN
         if (c == 8'h0C && !m_rel) m_pause = !m_pause;
`else
         if (c == 8'h0C) m_pause = !m_rel;
`endif
      end
   endfunction

   function automatic void model_byte(input logic [7:0] c);
      if (m_skip > 0) m_skip--;
      else if (c == 8'hAA || c == 8'h00 || c == 8'hFF) begin model_clear(); model_err(); end
      else if (c == 8'hE1) begin model_err(); m_skip = 7; end
      else if (c == 8'hE0 && !m_ext && !m_rel) m_ext = 1;
      else if (c == 8'hF0 && !m_rel) m_rel = 1;
      else begin model_apply(c); model_err(); end
   endfunction

   // scoreboard: every good frame must appear on rx_byte in order
   always @(negedge clk) begin
      if (rx_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rx_byte unexpected strobe got=%h", rx_byte);
         end else begin
            exp_b = exp_q.pop_front();
            if (rx_byte !== exp_b) begin
               bad++;
               $display("FAIL rx_byte got=%h want=%h", rx_byte, exp_b);
            end
         end
      end
      if (rx_err) err_seen++;
   end

   // drivers
   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         repeat (HALF) @(posedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(posedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_par);
      logic par;
      par = (~^b) ^ bad_par;
      if (!bad_par) exp_q.push_back(b);
      send_bits({1'b1, par, b, 1'b0}, 11);
      repeat (6) @(posedge clk);
      if (bad_par) begin err_exp++; model_err(); end
      else model_byte(b);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      model_clear(); model_err();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      ps2_clk = 1'b1; ps2_data = 1'b1;
      do_reset();
      total++; if (key_joy !== '0) begin bad++; $display("FAIL reset_joy got=%h want=0", key_joy); end
      total++; if ({key_coin, key_start} !== '0) begin bad++; $display("FAIL reset_coin_start got=%h want=0", {key_coin, key_start}); end
      total++; if ({key_service, key_reset, key_pause} !== 3'b000) begin bad++; $display("FAIL reset_sys got=%b want=000", {key_service, key_reset, key_pause}); end
      total++; if (rx_byte !== 8'h00) begin bad++; $display("FAIL reset_rx_byte got=%h want=00", rx_byte); end
      total++; if ({rx_valid, rx_err} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b want=00", {rx_valid, rx_err}); end
      total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
   endtask

   task automatic test_basic();
      send_byte(8'h14, 0);
      total++; if (key_joy[4] !== 1'b1) begin bad++; $display("FAIL p1_b1_press got=%b want=1", key_joy[4]); end
      send_byte(8'hF0, 0); send_byte(8'h14, 0);
      total++; if (key_joy[4] !== 1'b0) begin bad++; $display("FAIL p1_b1_release got=%b want=0", key_joy[4]); end
   endtask

   task automatic test_ext();
      send_byte(8'hE0, 0); send_byte(8'h75, 0);
      total++; if (key_joy[3] !== 1'b1) begin bad++; $display("FAIL p1_up_press got=%b want=1", key_joy[3]); end
      send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);
      total++; if (key_joy[3] !== 1'b0) begin bad++; $display("FAIL p1_up_release got=%b want=0", key_joy[3]); end
      send_byte(8'h2D, 0);
      total++; if (key_joy[11] !== 1'b1) begin bad++; $display("FAIL p2_up_press got=%b want=1", key_joy[11]); end
      send_byte(8'h75, 0);
      total++; if (key_joy[3] !== 1'b0) begin bad++; $display("FAIL plain_75_ignored got=%b want=0", key_joy[3]); end
   endtask

   task automatic test_parity();
      int e0;
      e0 = err_seen;
      send_byte(8'h1C, 1);
      total++; if (err_seen !== e0 + 1) begin bad++; $display("FAIL parity_err_count got=%0d want=%0d", err_seen, e0 + 1); end
      total++; if (key_joy[12] !== 1'b0) begin bad++; $display("FAIL parity_key_unchanged got=%b want=0", key_joy[12]); end
      send_byte(8'h1C, 0);
      total++; if (key_joy[12] !== 1'b1) begin bad++; $display("FAIL parity_recover got=%b want=1", key_joy[12]); end
   endtask

   task automatic test_timeout();
      int e0;
      e0 = err_seen;
      send_bits({1'b1, 1'b0, 8'h16, 1'b0}, 5);
      repeat (int'(TO) + 20) @(posedge clk);
      @(negedge clk);
      err_exp++; model_err();
      total++; if (err_seen !== e0 + 1) begin bad++; $display("FAIL timeout_err got=%0d want=%0d", err_seen, e0 + 1); end
      send_byte(8'h16, 0);
      total++; if (key_start[0] !== 1'b1) begin bad++; $display("FAIL timeout_recover got=%b want=1", key_start[0]); end
   endtask

   task automatic test_skip();
      logic [P*W-1:0] sj;
      logic [2*P+2:0] so;
      logic [7:0] seq[8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      sj = key_joy;
      so = {key_coin, key_start, key_service, key_reset, key_pause};
      for (int i = 0; i < 8; i++) send_byte(seq[i], 0);
      total++; if (key_joy !== sj) begin bad++; $display("FAIL skip_joy got=%h want=%h", key_joy, sj); end
      total++; if ({key_coin, key_start, key_service, key_reset, key_pause} !== so) begin bad++; $display("FAIL skip_other got=%b want=%b", {key_coin, key_start, key_service, key_reset, key_pause}, so); end
      total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL skip_state got=%0d want=0", dbg_state); end
      send_byte(8'h2E, 0);
      total++; if (key_coin[0] !== 1'b1) begin bad++; $display("FAIL coin1 got=%b want=1", key_coin[0]); end
      send_byte(8'hAA, 0);
      total++; if ({key_joy, key_coin, key_start, key_service, key_reset, key_pause} !== '0) begin bad++; $display("FAIL aa_clear got=%h want=0", {key_joy, key_coin, key_start, key_service, key_reset, key_pause}); end
   endtask

   task automatic test_pause();
      logic [3:0] want;
`ifdef JTFRAME_KEYMAP_PAUSE_TOGGLE_EN
      want = 4'b1100;
`else
      want = 4'b1010;
`endif
      send_byte(8'h0C, 0);
      total++; if (key_pause !== want[3]) begin bad++; $display("FAIL pause_1 got=%b want=%b", key_pause, want[3]); end
      send_byte(8'hF0, 0); send_byte(8'h0C, 0);
      total++; if (key_pause !== want[2]) begin bad++; $display("FAIL pause_2 got=%b want=%b", key_pause, want[2]); end
      send_byte(8'h0C, 0);
      total++; if (key_pause !== want[1]) begin bad++; $display("FAIL pause_3 got=%b want=%b", key_pause, want[1]); end
      send_byte(8'hF0, 0); send_byte(8'h0C, 0);
      total++; if (key_pause !== want[0]) begin bad++; $display("FAIL pause_4 got=%b want=%b", key_pause, want[0]); end
   endtask

   task automatic test_random();
      int r;
      logic [7:0] c;
      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 99);
         if (r < 3) send_byte(8'hAA, 0);
         else begin
            c = pool[$urandom_range(0, 36)];
            if (r % 4 == 0) send_byte(8'hE0, 0);
            if (r < 45) send_byte(8'hF0, 0);
            send_byte(c, ($urandom_range(0, 24) == 0));
         end
         total++; if (key_joy !== m_joy) begin bad++; $display("FAIL rnd_joy n=%0d got=%h want=%h", n, key_joy, m_joy); end
         total++; if (key_coin !== m_coin) begin bad++; $display("FAIL rnd_coin n=%0d got=%b want=%b", n, key_coin, m_coin); end
         total++; if (key_start !== m_start) begin bad++; $display("FAIL rnd_start n=%0d got=%b want=%b", n, key_start, m_start); end
         total++; if ({key_service, key_reset, key_pause} !== {m_svc, m_rst, m_pause}) begin bad++; $display("FAIL rnd_sys n=%0d got=%b want=%b", n, {key_service, key_reset, key_pause}, {m_svc, m_rst, m_pause}); end
      end
   endtask

   task automatic test_reset_mid();
      send_byte(8'h2D, 0);
      send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 4);
      @(posedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      total++; if ({key_joy, key_coin, key_start, key_service, key_reset, key_pause} !== '0) begin bad++; $display("FAIL midreset_keys got=%h want=0", {key_joy, key_coin, key_start, key_service, key_reset, key_pause}); end
      total++; if (rx_byte !== 8'h00) begin bad++; $display("FAIL midreset_rx_byte got=%h want=00", rx_byte); end
      do_reset();
      send_byte(8'h14, 0);
      total++; if (key_joy !== 16'h0010) begin bad++; $display("FAIL midreset_fresh got=%h want=0010", key_joy); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ext();
      test_parity();
      test_timeout();
      test_skip();
      test_pause();
      test_random();
      test_reset_mid();
      repeat (20) @(posedge clk);
      @(negedge clk);
      total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rx_pending got=%0d want=0", exp_q.size()); end
      total++; if (err_seen !== err_exp) begin bad++; $display("FAIL rx_err_count got=%0d want=%0d", err_seen, err_exp); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
